// File: rtl/pw_stream_pkg.sv
// pw_stream_pkg: shared types and width helpers for the feature-map streamer.
//   streamer_state_t : frame sequencer states
//   idx_w()          : index width for a count of n items (at least 1 bit)
//   DEF_*_W          : index widths for the default 40-channel, 14x14 map
package pw_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        DONE
    } streamer_state_t;

    localparam int unsigned GAP_W = 8;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_CH_W   = idx_w(40);
    localparam int unsigned DEF_PIX_W  = idx_w(14 * 14);
    localparam int unsigned DEF_ADDR_W = idx_w(40 * 14 * 14);

endpackage

// File: rtl/fm_buffer_ram.sv
// fm_buffer_ram: simple dual-port feature-map store, one write port and one
// read port with a single-cycle registered read.
//   clk             : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr   : read request; rd_data is valid the cycle after rd_en
//   rd_data         : registered read data (holds when rd_en is low)
module fm_buffer_ram
    import pw_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 7840,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pw_feature_streamer.sv
// pw_feature_streamer: holds one quantized feature map and streams it
// pixel-major, channel-fastest, with an idle gap after every pixel.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : map load port (addr = pixel*IN_CHANNELS + channel)
//   wr_err            : pulse when a write is dropped (busy or out of range)
//   start             : begin a frame (honoured in IDLE/DONE only)
//   ready_in          : downstream accepts the current beat
//   data_out, channel_out, pixel_out, last_ch, valid_out : beat
//   busy              : frame in progress
//   done              : pulse the cycle after the final beat is accepted
module pw_feature_streamer
    import pw_stream_pkg::*;
#(
    parameter int unsigned N            = 16,
    parameter int unsigned Q            = 8,
    parameter int unsigned IN_CHANNELS  = 40,
    parameter int unsigned FEATURE_SIZE = 14,
    parameter int unsigned GAP_CYCLES   = 4,
    localparam int unsigned NPIX  = FEATURE_SIZE * FEATURE_SIZE,
    localparam int unsigned TOTAL = IN_CHANNELS * NPIX,
    localparam int unsigned AW    = idx_w(TOTAL),
    localparam int unsigned CH_W  = idx_w(IN_CHANNELS),
    localparam int unsigned PIX_W = idx_w(NPIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_data,
    output logic             wr_err,
    input  logic             start,
    input  logic             ready_in,
    output logic [N-1:0]     data_out,
    output logic [CH_W-1:0]  channel_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic             valid_out,
    output logic             last_ch,
    output logic             busy,
    output logic             done
);

    if (Q > N || GAP_CYCLES > 255) begin : g_bad_cfg
        $error("pw_feature_streamer: Q must not exceed N and GAP_CYCLES must fit 8 bits");
    end

    streamer_state_t  state;
    logic [AW-1:0]    iss_addr;
    logic             iss_active;
    logic             rd_pend;
    logic [1:0]       occ;
    logic [N-1:0]     skid;
    logic [GAP_W-1:0] gap_cnt;
    logic [N-1:0]     rd_data;

    logic             pop;
    logic             pix_end;
    logic             frame_end;
    logic             wr_ok;
    logic             issue;
    logic [1:0]       occ_after;

    // data_out is the head of a 2-entry queue (data_out, skid). A read is
    // issued only if the queue, counting the read already in flight, can
    // still take it after this cycle's pop; that keeps 1 beat/cycle without
    // ever losing a RAM word on a stall, and keeps prefetching through GAP.
    always_comb begin
        pop       = valid_out & ready_in;
        pix_end   = pop & last_ch;
        frame_end = pix_end & (pixel_out == PIX_W'(NPIX - 1));
        occ_after = occ + {1'b0, rd_pend} - {1'b0, pop};
        issue     = iss_active & (occ_after < 2'd2);
        wr_ok     = wr_en & ({1'b0, wr_addr} < (AW + 1)'(TOTAL))
                    & ((state == IDLE) | (state == DONE));
    end

    fm_buffer_ram #(
        .DEPTH(TOTAL),
        .WIDTH(N)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_ok),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (issue),
        .rd_addr(iss_addr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            iss_addr    <= '0;
            iss_active  <= 1'b0;
            rd_pend     <= 1'b0;
            occ         <= '0;
            skid        <= '0;
            gap_cnt     <= '0;
            data_out    <= '0;
            channel_out <= '0;
            pixel_out   <= '0;
            valid_out   <= 1'b0;
            last_ch     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            done    <= 1'b0;
            wr_err  <= wr_en & ~wr_ok;
            rd_pend <= issue;

            if (issue) begin
                iss_addr <= iss_addr + 1'b1;
                if (iss_addr == AW'(TOTAL - 1)) begin
                    iss_active <= 1'b0;
                end
            end

            case ({rd_pend, pop})
                2'b10: begin
                    if (occ == 2'd0) data_out <= rd_data;
                    else             skid     <= rd_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data_out <= skid;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        data_out <= skid;
                        skid     <= rd_data;
                    end else begin
                        data_out <= rd_data;
                    end
                end
                default: ;
            endcase

            // Beat indices hold on the final beat so DONE shows the last beat.
            if (pop && !frame_end) begin
                if (last_ch) begin
                    channel_out <= '0;
                    pixel_out   <= pixel_out + 1'b1;
                    last_ch     <= (IN_CHANNELS == 1);
                end else begin
                    channel_out <= channel_out + 1'b1;
                    last_ch     <= (channel_out == CH_W'(IN_CHANNELS - 2));
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= STREAM;
                        busy        <= 1'b1;
                        iss_addr    <= '0;
                        iss_active  <= 1'b1;
                        channel_out <= '0;
                        pixel_out   <= '0;
                        last_ch     <= (IN_CHANNELS == 1);
                        valid_out   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (frame_end) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        valid_out <= 1'b0;
                    end else if (pix_end && GAP_CYCLES > 0) begin
                        state     <= GAP;
                        gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
                        valid_out <= 1'b0;
                    end else begin
                        valid_out <= (occ_after != 2'd0);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state     <= STREAM;
                        valid_out <= (occ_after != 2'd0);
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_feature_streamer.sv
// tb_pw_feature_streamer: scoreboard bench for pw_feature_streamer.
// Main instance: 4 channels, 2x2 map, gap 2. Second instance: gap 0.
// Third instance (default geometry): out-of-range write rejection.
module tb_pw_feature_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en_a, wr_en_b, wr_en_d;
    logic [12:0] wr_addr_d;

    logic        start, ready_in;
    logic        wr_err, valid_out, last_ch, busy, done;
    logic [15:0] data_out;
    logic [1:0]  channel_out, pixel_out;

    logic        start_b, ready_b;
    logic        wr_err_b, valid_b, last_ch_b, busy_b, done_b;
    logic [15:0] data_b;
    logic [1:0]  channel_b, pixel_b;

    logic        start_d, ready_d;
    logic        wr_err_d, valid_d, last_ch_d, busy_d, done_d;
    logic [15:0] data_d;
    logic [5:0]  channel_d;
    logic [7:0]  pixel_d;

    typedef struct {
        logic [15:0] data;
        int unsigned ch;
        int unsigned pix;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] mem_m [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_xfer   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pw_feature_streamer #(.IN_CHANNELS(4), .FEATURE_SIZE(2), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .start(start), .ready_in(ready_in), .data_out(data_out),
        .channel_out(channel_out), .pixel_out(pixel_out), .valid_out(valid_out),
        .last_ch(last_ch), .busy(busy), .done(done)
    );

    pw_feature_streamer #(.IN_CHANNELS(4), .FEATURE_SIZE(2), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err_b), .start(start_b), .ready_in(ready_b), .data_out(data_b),
        .channel_out(channel_b), .pixel_out(pixel_b), .valid_out(valid_b),
        .last_ch(last_ch_b), .busy(busy_b), .done(done_b)
    );

    pw_feature_streamer u_dut_def (
        .clk(clk), .rst(rst), .wr_en(wr_en_d), .wr_addr(wr_addr_d), .wr_data(wr_data),
        .wr_err(wr_err_d), .start(start_d), .ready_in(ready_d), .data_out(data_d),
        .channel_out(channel_d), .pixel_out(pixel_d), .valid_out(valid_d),
        .last_ch(last_ch_d), .busy(busy_d), .done(done_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back('{mem_m[p*4+c], c, p});
    endtask

    // Monitor for the main instance: scoreboard pops, stall hold, gap length.
    logic        stall_pend = 1'b0;
    logic        after_last = 1'b0;
    int          lo_cnt     = 0;
    logic [15:0] h_data;
    logic [1:0]  h_ch, h_pix;
    logic        h_last;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_pend = 1'b0;
            after_last = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", valid_out, 1);
                check("hold_data", data_out, h_data);
                check("hold_ch", channel_out, h_ch);
                check("hold_pix", pixel_out, h_pix);
                check("hold_last", last_ch, h_last);
            end
            if (after_last) begin
                if (valid_out) begin
                    check("gap_len", lo_cnt, 2);
                    after_last = 1'b0;
                end else begin
                    lo_cnt++;
                end
            end
            stall_pend = valid_out && !ready_in;
            h_data = data_out; h_ch = channel_out; h_pix = pixel_out; h_last = last_ch;
            if (valid_out && ready_in) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", data_out, e.data);
                    check("beat_ch", channel_out, e.ch);
                    check("beat_pix", pixel_out, e.pix);
                    check("beat_last", last_ch, e.ch == 3);
                    if (e.ch == 3 && e.pix != 3) begin
                        after_last = 1'b1;
                        lo_cnt     = 0;
                    end
                end
            end
        end
    end

    // One frame on the main instance. start held for hold_cycles cycles,
    // ready dropped for stall_cycles while pixel1/ch2 is presented, and an
    // optional write driven at loop iteration wr_iter (during STREAM).
    task automatic run_frame(input int stall_cycles, input int hold_cycles,
                             input int wr_iter, input int exp_len);
        int t0, stall_left;
        bit seen_done;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1; ready_in = 1'b1;
        t0 = cyc + 1;
        stall_left = stall_cycles;
        seen_done = 1'b0;
        for (int i = 1; i < 200 && !seen_done; i++) begin
            @(posedge clk); #1;
            if (i >= hold_cycles) start = 1'b0;
            wr_en_a = 1'b0;
            if (i == wr_iter) begin
                wr_en_a = 1'b1; wr_addr = 4'd0; wr_data = 16'hDEAD;
            end
            if (wr_iter >= 0 && i == wr_iter + 1) check("wr_err_stream", wr_err, 1);
            ready_in = 1'b1;
            if (stall_left > 0 && valid_out && pixel_out == 2'd1 && channel_out == 2'd2) begin
                ready_in = 1'b0;
                stall_left--;
            end
            if (i == 1) check("busy_after_start", busy, 1);
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", cyc - t0, exp_len);
                check("busy_at_done", busy, 0);
            end
        end
        start = 1'b0;
        if (!seen_done) check("done_timeout", 0, 1);
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
    endtask

    initial begin
        int t0, nb, first, last, base;
        bit seen;
        rst = 1'b1; start = 1'b0; ready_in = 1'b1;
        start_b = 1'b0; ready_b = 1'b1; start_d = 1'b0; ready_d = 1'b1;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_en_d = 1'b0;
        wr_addr = '0; wr_addr_d = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid", valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_data", data_out, 0);
        check("rst_ch", channel_out, 0);
        check("rst_pix", pixel_out, 0);
        check("rst_last", last_ch, 0);
        check("rst_valid_b", valid_b, 0);

        // Load both 2x2 instances with word i = 0x0100 + i.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en_a = 1'b1; wr_en_b = 1'b1;
            wr_addr = 4'(i); wr_data = 16'h0100 + 16'(i);
            mem_m[i] = 16'h0100 + 16'(i);
            if (i > 0) check("wr_err_load", wr_err, 0);
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
        check("wr_err_load", wr_err, 0);

        // Zero-gap instance: 16 back-to-back beats, done at cycle 18.
        @(posedge clk); #1;
        start_b = 1'b1; t0 = cyc + 1;
        nb = 0; first = -1; last = -1; seen = 1'b0;
        for (int i = 1; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (valid_b) begin
                if (first < 0) first = cyc - t0;
                last = cyc - t0;
                if (nb < 16) begin
                    check("b_data", data_b, mem_m[nb]);
                    check("b_ch", channel_b, nb % 4);
                    check("b_pix", pixel_b, nb / 4);
                end else begin
                    check("b_extra_beat", 1, 0);
                end
                nb++;
            end
            if (done_b) begin
                seen = 1'b1;
                check("b_done_cycle", cyc - t0, 18);
            end
        end
        if (!seen) check("b_done_timeout", 0, 1);
        check("b_first_valid", first, 2);
        check("b_valid_span", last - first, 15);
        check("b_beats", nb, 16);

        // Default-geometry instance: address range check.
        @(posedge clk); #1;
        wr_en_d = 1'b1; wr_addr_d = 13'd7840; wr_data = 16'h1234;
        @(posedge clk); #1;
        wr_addr_d = 13'd7839;
        check("range_err", wr_err_d, 1);
        @(posedge clk); #1;
        wr_en_d = 1'b0;
        check("range_ok", wr_err_d, 0);

        // Nominal frame.
        run_frame(0, 1, -1, 24);

        // Write accepted in DONE, then replay from DONE picks it up.
        @(posedge clk); #1;
        wr_en_a = 1'b1; wr_addr = 4'd15; wr_data = 16'h0AAA; mem_m[15] = 16'h0AAA;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        check("wr_err_done", wr_err, 0);
        run_frame(0, 1, -1, 24);
        @(posedge clk); #1;
        wr_en_a = 1'b1; wr_addr = 4'd15; wr_data = 16'h010F; mem_m[15] = 16'h010F;
        @(posedge clk); #1;
        wr_en_a = 1'b0;

        // Held start, 3-cycle stall on pixel1/ch2, write during STREAM.
        run_frame(3, 10, 5, 27);

        // Reset after 5 beats; the rejected write must not have landed.
        push_frame();
        base = n_xfer;
        @(posedge clk); #1;
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n_xfer - base >= 5) seen = 1'b1;
        end
        if (!seen) check("reset_wait_timeout", 0, 1);
        rst = 1'b1; ready_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", valid_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ch", channel_out, 0);
        check("midrst_pix", pixel_out, 0);
        ready_in = 1'b1;
        exp_q.delete();
        run_frame(0, 1, -1, 24);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
